// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helper for serial_adder
// Contents:
//   state_e    control FSM states IDLE=2'b00, SHIFT=2'b01, DONE=2'b10
//   cnt_width  bit-counter width, max(1, clog2(w))
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // A one-bit adder still needs a one-bit counter; clog2(1) would give zero.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - one-bit full-adder slice built from two half-adder cells
// serial_adder_ha ports:
//   a, b   in   addend bits
//   s      out  a ^ b
//   c      out  a & b
// serial_adder_fa ports:
//   a, b   in   addend bits
//   cin    in   carry in
//   s      out  sum bit
//   cout   out  carry out
module serial_adder_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    serial_adder_ha u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    serial_adder_ha u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    // The two half-adder carries can never both be 1, so OR is exact.
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted in IDLE or DONE
//   a, b   in   WIDTH-bit operands, sampled at the accept edge
//   cin    in   carry-in, sampled at the accept edge
//   busy   out  high while shifting
//   done   out  one-cycle pulse, results valid
//   sum    out  registered WIDTH-bit result, held until the next completion
//   cout   out  registered carry-out of the MSB
//   ovf    out  registered signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q,  a_sh_d;
    logic [WIDTH-1:0] b_sh_q,  b_sh_d;
    logic [WIDTH-1:0] s_sh_q,  s_sh_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] s_shifted;

    serial_adder_fa u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .cout(fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_s_one
            assign s_shifted = fa_s;
        end else begin : g_s_many
            assign s_shifted = {fa_s, s_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    count_d = '0;
                    state_d = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = s_shifted;
                carry_d = fa_c;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    sum_d   = s_shifted;
                    cout_d  = fa_c;
                    // carry_q is the carry into the MSB on this last edge.
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Each status bit is a single state flop, so neither can glitch.
    assign busy = state_q[0];
    assign done = state_q[1];
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard testbench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;
    logic prev_done8 = 1'b0;
    logic prev_done1 = 1'b0;
    logic [9:0] hold8 = '0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from range test.
    function automatic exp_t model(input int w, input int av, input int bv, input int cv, input int acc);
        exp_t r;
        int   tot, half, sa, sb, st;
        half   = 1 << (w - 1);
        tot    = av + bv + cv;
        r.sum  = 8'(tot & ((1 << w) - 1));
        r.cout = (tot >= (1 << w));
        sa     = (av >= half) ? av - 2 * half : av;
        sb     = (bv >= half) ? bv - 2 * half : bv;
        st     = sa + sb + cv;
        r.ovf  = (st > half - 1) || (st < -half);
        r.acc  = acc;
        return r;
    endfunction

    // Monitors: pop and compare whenever a DUT presents done.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done8 === 1'b1) begin
                if (q8.size() == 0) begin
                    chk(1'b0, "unexpected_done8", 1, 0);
                end else begin
                    e8 = q8.pop_front();
                    chk(sum8 === e8.sum, "sum8", sum8, e8.sum);
                    chk(cout8 === e8.cout, "cout8", cout8, e8.cout);
                    chk(ovf8 === e8.ovf, "ovf8", ovf8, e8.ovf);
                    chk(cyc - e8.acc == 8, "latency8", cyc - e8.acc, 8);
                end
                chk(prev_done8 === 1'b0, "done_pulse8", prev_done8, 0);
            end
            if (busy8 === 1'b1)
                chk({cout8, ovf8, sum8} === hold8, "hold8", {cout8, ovf8, sum8}, hold8);
        end
        prev_done8 = done8;
        hold8      = {cout8, ovf8, sum8};
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    chk(1'b0, "unexpected_done1", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    chk(sum1 === e1.sum[0], "sum1", sum1, e1.sum[0]);
                    chk(cout1 === e1.cout, "cout1", cout1, e1.cout);
                    chk(ovf1 === e1.ovf, "ovf1", ovf1, e1.ovf);
                    chk(cyc - e1.acc == 1, "latency1", cyc - e1.acc, 1);
                end
                chk(prev_done1 === 1'b0, "done_pulse1", prev_done1, 0);
            end
        end
        prev_done1 = done1;
    end

    // Called just after a negedge; returns at the negedge where done shows.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        q8.push_back(model(8, av, bv, cv, cyc + 1));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk(busy8 === 1'b1 && done8 === 1'b0, "busy_phase8", {busy8, done8}, 2'b10);
        end
        @(negedge clk);
        chk(busy8 === 1'b0 && done8 === 1'b1, "done_phase8", {busy8, done8}, 2'b01);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            chk(busy8 === 1'b0 && done8 === 1'b0, "idle8", {busy8, done8}, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk({busy8, done8, cout8, ovf8, sum8} === 12'h0, "reset8",
            {busy8, done8, cout8, ovf8, sum8}, 0);
        chk({busy1, done1, cout1, ovf1, sum1} === 5'h0, "reset1",
            {busy1, done1, cout1, ovf1, sum1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h35, 8'h4A, 1'b0);
        idle(2);
        do_op(8'hFF, 8'h01, 1'b0);
        idle(1);
        do_op(8'h7F, 8'h01, 1'b0);
        idle(1);

        // Back-to-back: second start lands in the DONE cycle.
        do_op(8'h35, 8'h4A, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1);
        idle(2);

        // start held high with operands changing every cycle.
        for (int i = 0; i < 5 * 9; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            start8 = 1'b1;
            if (i % 9 == 0)
                q8.push_back(model(8, a8, b8, cin8, cyc + 1));
            @(negedge clk);
        end
        start8 = 1'b0;
        idle(2);

        // Reset after 4 SHIFT edges: immediate zero outputs, no done afterwards.
        a8 = 8'hA5; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk({busy8, done8, cout8, ovf8, sum8} === 12'h0, "async_reset8",
            {busy8, done8, cout8, ovf8, sum8}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        do_op(8'h10, 8'h20, 1'b1);
        idle(1);

        // WIDTH=1: exhaustive over a, b, cin.
        for (int k = 7; k >= 0; k--) begin
            a1 = 1'(k >> 2); b1 = 1'(k >> 1); cin1 = 1'(k);
            start1 = 1'b1;
            q1.push_back(model(1, a1, b1, cin1, cyc + 1));
            @(posedge clk);
            #1;
            start1 = 1'b0;
            @(negedge clk);
            chk(busy1 === 1'b1 && done1 === 1'b0, "busy_phase1", {busy1, done1}, 2'b10);
            @(negedge clk);
            chk(busy1 === 1'b0 && done1 === 1'b1, "done_phase1", {busy1, done1}, 2'b01);
            @(negedge clk);
        end

        // Random operations with random gaps or back-to-back starts.
        for (int n = 0; n < 1000; n++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1)
                idle($urandom_range(1, 2));
        end
        idle(3);

        chk(q8.size() == 0, "drain8", q8.size(), 0);
        chk(q1.size() == 0, "drain1", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around the team's existing one-bit FA slice plus a carry flip-flop.
- Accepts two operands and a carry-in with a start/busy/done handshake, then adds one bit per clock, LSB first.
- Produces a registered sum, carry-out and signed-overflow flag.
- Sits where area matters more than latency; it is the sequential consumer of the FA cell.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on an edge where busy=0
- a  input  WIDTH  operand A, sampled at the accept edge
- b  input  WIDTH  operand B, sampled at the accept edge
- cin  input  1  carry-in, sampled at the accept edge
- busy  output  1  high while shifting (state SHIFT)
- done  output  1  one-cycle pulse; results valid
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered carry-out of bit WIDTH-1
- ovf  output  1  registered signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers, carry and count all 0.
- States: IDLE, SHIFT, DONE.
- busy=1 only in SHIFT; done=1 only in DONE. Both are decoded from registered state and are glitch-free.
- Accept rule:
  - Any edge with start=1 in IDLE or DONE loads a_sh<=a, b_sh<=b, carry<=cin, count<=0, state<=SHIFT.
  - start in SHIFT is ignored; there is no queueing.
- SHIFT edge, using one FA with inputs a_sh[0], b_sh[0], carry:
  - The FA sum bit enters the MSB of s_sh, and s_sh shifts right.
  - a_sh and b_sh shift right; carry<=FA carry; count<=count+1.
  - At count==WIDTH-1 (last bit):
    - sum<={FA sum, s_sh[WIDTH-1:1]}
    - cout<=FA carry
    - ovf<=carry XOR FA carry (carry here is the carry into the MSB)
    - state<=DONE
- DONE:
  - With start=0, go to IDLE.
  - With start=1, accept a new operation (back-to-back, no bubble).
- Latency: accept at edge k; done is high in the cycle after edge k+WIDTH. Throughput is one add per WIDTH+1 cycles.
- sum, cout and ovf change only on the final SHIFT edge and on reset. They hold through IDLE and the next operation's SHIFT phase.
- Count register width is max(1, clog2(WIDTH)). WIDTH=1 completes after a single SHIFT edge.
- Reset mid-operation aborts immediately: all outputs go to 0 and no done is produced. A start after release behaves normally.
- Arithmetic is modulo 2^WIDTH. {cout,sum} = a + b + cin exactly.

Decomposition:
- Shared package/include: state encoding constants IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
- Single sub-module: reuse the existing FA cell (built from two HA cells) as the bit slice. It is instantiated once; no new adder logic.
- The control FSM, shift registers and count stay in serial_adder.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> busy=0, done=0, sum=8'h00, cout=0, ovf=0 immediately (asynchronous).
- Basic add: a=8'h35, b=8'h4A, cin=0, start one cycle -> busy high 8 cycles, done pulses exactly one cycle, 8 cycles after the accept edge; sum=8'h7F, cout=0, ovf=0.
- Carry and overflow:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- Handshake:
  - start held high throughout an operation with changing a/b -> operands are taken only at accept edges.
  - start asserted in the DONE cycle with a=8'hFF, b=8'hFF, cin=1 -> immediate re-accept; next done 8 cycles later with sum=8'hFF, cout=1, ovf=0.
  - Outputs are stable during the second SHIFT phase.
- Reset mid-operation: assert rst_n=0 after 4 SHIFT edges -> outputs 0, no done pulse. Then a=8'h10, b=8'h20, cin=1 -> sum=8'h31.
- WIDTH=1 instance: a=1, b=1, cin=1 -> done after one SHIFT edge; sum=1, cout=1, ovf=0.
- Random: 1000 random a/b/cin compared against a + b + cin reference.
